// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state encoding and the round/schedule bit functions
// shared by the round sequencer and its message schedule.
package sha256_pkg;

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-word rolling message schedule window; w_o is always W[t] for the current round.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         advance_i,
  input  logic [511:0] block_i,
  output logic [31:0]  w_o
);

  logic [15:0][31:0] w_q, w_d;

  always_comb begin
    w_d = w_q;
    if (load_i) begin
      for (int i = 0; i < 16; i++) begin
        w_d[i] = block_i[511 - 32 * i -: 32];
      end
    end else if (advance_i) begin
      for (int i = 0; i < 15; i++) begin
        w_d[i] = w_q[i + 1];
      end
      // Slot k holds W[t+k]; the new tail is W[t+16].
      w_d[15] = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_q <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  assign w_o = w_q[0];

endmodule

// File: rtl/sha256_round_sequencer.sv
// One-round-per-cycle SHA-256 compression sequencer with valid/ready block input
// and digest output handshakes.
module sha256_round_sequencer
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 64,
  parameter int unsigned ADD_CHAIN  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block,
  input  logic [255:0] h_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         busy,
  output logic [5:0]   round_idx
);

  localparam logic [5:0] LastRound = 6'(NUM_ROUNDS - 1);

  state_e        state_q;
  logic [5:0]    round_q;
  logic [31:0]   a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [255:0]  chain_q, digest_q;
  logic          in_ready_q, out_valid_q, busy_q;

  logic [31:0]   w_t, t1, t2;
  logic [255:0]  work, digest_d;
  logic          sched_load, sched_adv;

  assign sched_load = (state_q == StIdle) && in_valid;
  assign sched_adv  = (state_q == StRound);

  sha256_msg_schedule u_sched (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (sched_load),
    .advance_i (sched_adv),
    .block_i   (block),
    .w_o       (w_t)
  );

  always_comb begin
    t1   = h_q + big_sigma1(e_q) + ch(e_q, f_q, g_q) + K[round_q] + w_t;
    t2   = big_sigma0(a_q) + maj(a_q, b_q, c_q);
    work = {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
    digest_d = work;
    if (ADD_CHAIN != 0) begin
      for (int i = 0; i < 8; i++) begin
        digest_d[32 * i +: 32] = chain_q[32 * i +: 32] + work[32 * i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      round_q     <= '0;
      {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= '0;
      chain_q     <= '0;
      digest_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= h_in;
            chain_q    <= h_in;
            round_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StRound;
          end
        end
        StRound: begin
          {a_q, b_q, c_q, d_q} <= {t1 + t2, a_q, b_q, c_q};
          {e_q, f_q, g_q, h_q} <= {d_q + t1, e_q, f_q, g_q};
          // Counter parks on the last round rather than wrapping.
          if (round_q == LastRound) begin
            state_q <= StFinal;
          end else begin
            round_q <= round_q + 6'd1;
          end
        end
        StFinal: begin
          digest_q    <= digest_d;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign digest    = digest_q;
  assign round_idx = round_q;

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Scoreboard bench: sends known and random blocks, checks digests against
// published vectors and a plain-loop SHA-256 compression model.
module tb_sha256_round_sequencer;
  import sha256_pkg::*;

  localparam int NumRounds = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] block = '0;
  logic [255:0] h_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] digest;
  logic         busy;
  logic [5:0]   round_idx;

  int n_checks = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int acc_edge = 0;
  int stall_left = 0;
  bit rand_or = 1'b0;
  logic [255:0] exp_q[$];

  localparam logic [511:0] AbcBlk   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EmptyBlk = {32'h80000000, 480'h0};
  localparam logic [511:0] TwoBlk1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TwoBlk2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] AbcDig   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EmptyDig = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TwoDig   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  sha256_round_sequencer #(
    .NUM_ROUNDS (NumRounds),
    .ADD_CHAIN  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .block     (block),
    .h_in      (h_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digest    (digest),
    .busy      (busy),
    .round_idx (round_idx)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: expand all 64 words up front, then iterate rounds.
  function automatic logic [255:0] ref_compress(input logic [511:0] b, input logic [255:0] h);
    logic [31:0] w[64];
    logic [31:0] v[8];
    logic [31:0] x1, x2, s0, s1;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h[255 - 32 * i -: 32];
    for (int t = 0; t < NumRounds; t++) begin
      x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
           + K[t] + w[t];
      x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = h[255 - 32 * i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32 * i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand_h();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32 * i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic send(input logic [511:0] b, input logic [255:0] h, input logic [255:0] exp);
    int n = 0;
    @(negedge clk);
    block = b;
    h_in = h;
    in_valid = 1'b1;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 256'(in_ready), 256'(1));
    end else begin
      exp_q.push_back(exp);
      acc_edge = edge_cnt + 1;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    block = rand_block();
    h_in = rand_h();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 256'(exp_q.size()), 256'(0));
  endtask

  // Monitor: owns out_ready, pops the scoreboard on every output handshake.
  initial begin
    logic         prev_ov = 1'b0, prev_stall = 1'b0, prev_busy = 1'b0;
    logic [255:0] prev_digest = '0;
    logic [5:0]   prev_round = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("in_ready_vs_busy", 256'(in_ready), 256'(!busy));
        if (busy && prev_busy) check("round_no_wrap", 256'(round_idx >= prev_round), 256'(1));
        if (prev_stall) begin
          check("stall_digest", digest, prev_digest);
          check("stall_valid", 256'(out_valid), 256'(1));
          check("stall_round", 256'(round_idx), 256'(prev_round));
        end
        if (out_valid && !prev_ov) check("latency", 256'(edge_cnt - acc_edge), 256'(NumRounds + 1));
        if (stall_left > 0 && out_valid) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = rand_or ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_out_valid: actual digest %h required no output", digest);
          end else begin
            check("digest", digest, exp_q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_busy = busy;
      end else begin
        prev_stall = 1'b0;
        prev_busy = 1'b0;
      end
      prev_digest = digest;
      prev_round = round_idx;
      prev_ov = out_valid;
    end
  end

  task automatic check_reset_state();
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_round_idx", 256'(round_idx), 256'(0));
    check("rst_digest", digest, 256'(0));
  endtask

  initial begin
    logic [255:0] r1, exp;
    logic [511:0] b;
    logic [255:0] h;
    int prev_acc, n;

    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b1;

    send(AbcBlk, IV, AbcDig);
    send(EmptyBlk, IV, EmptyDig);
    r1 = ref_compress(TwoBlk1, IV);
    send(TwoBlk1, IV, r1);
    send(TwoBlk2, r1, TwoDig);
    drain();

    // Ignored input traffic while busy, then a 20-cycle output stall.
    stall_left = 20;
    send(AbcBlk, IV, AbcDig);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("in_ready_busy", 256'(in_ready), 256'(0));
      in_valid = 1'($urandom_range(0, 1));
      block = rand_block();
      h_in = rand_h();
    end
    in_valid = 1'b0;
    drain();

    // Reset during round 30 drops the block with no output.
    send(AbcBlk, IV, AbcDig);
    n = 0;
    while (round_idx != 6'd30 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_round30", 256'(round_idx), 256'(30));
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_state();
    rst = 1'b1;
    repeat (80) @(negedge clk);
    send(AbcBlk, IV, AbcDig);
    drain();

    // Back-to-back with out_ready held high.
    for (int i = 0; i < 4; i++) begin
      b = rand_block();
      h = rand_h();
      exp = ref_compress(b, h);
      prev_acc = acc_edge;
      send(b, h, exp);
      if (i > 0) check("accept_spacing", 256'(acc_edge - prev_acc), 256'(NumRounds + 3));
    end
    drain();

    // Random traffic with random output backpressure.
    rand_or = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = rand_block();
      h = rand_h();
      send(b, h, ref_compress(b, h));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
